// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter: owns the select of a shared 2:1 mux and holds a grant for a whole burst.
// Optional feature: define MUX_ARB_ROUND_ROBIN_EN for round-robin contention (default is fixed priority, A wins).
module mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_a,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic              i_last_a,
  output logic              o_gnt_a,
  input  logic              i_req_b,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic              i_last_b,
  output logic              o_gnt_b,
  output logic              o_sel,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_owner, last_owner_nxt;
  logic             prefer_b;
  state_t           winner;

  // Contention tie-break. From IDLE the stored pointer decides; on a release the
  // releasing owner is the new pointer, so the other requester is preferred.
  always_comb begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
    prefer_b = (state == IDLE) ? ~last_owner : (state == OWN_A);
`else
    prefer_b = 1'b0;
`endif
    if (i_req_a && (!i_req_b || !prefer_b)) winner = OWN_A;
    else if (i_req_b)                       winner = OWN_B;
    else                                    winner = IDLE;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_owner_nxt = last_owner;
    o_valid        = 1'b0;
    o_data         = '0;
    o_last         = 1'b0;
    o_gnt_a        = 1'b0;
    o_gnt_b        = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = winner;
        cnt_nxt   = '0;
      end
      OWN_A: begin
        o_valid = i_req_a;
        o_data  = i_data_a;
        o_last  = i_last_a;
        o_gnt_a = i_req_a & i_ready;
      end
      OWN_B: begin
        o_valid = i_req_b;
        o_data  = i_data_b;
        o_last  = i_last_b;
        o_gnt_b = i_req_b & i_ready;
      end
      default: state_nxt = IDLE;
    endcase

    // Accepted beat: count it, and release on last or on reaching the beat limit.
    if (o_gnt_a || o_gnt_b) begin
      cnt_nxt = cnt + 1'b1;
      if (o_last || (cnt_nxt == CNT_MAX)) begin
        last_owner_nxt = (state == OWN_B);
        state_nxt      = winner;
        cnt_nxt        = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  assign o_sel = (state == OWN_B);

endmodule
